// File: rtl/rr_mux_arbiter.sv
//------------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter and scheduler in front of a shared N-bit 4:1 data mux.
// Up to four requesters compete for one output bus. The block:
//   - picks a winner by scanning req from a rotating start index (ptr),
//   - drives a registered one-hot grant and the matching mux select,
//   - registers the selected requester's data onto F, with valid flagging it,
//   - limits every grant to MAX_HOLD consecutive transfers so no requester
//     can starve the others.
//
// Parameters
//   N         data width of each input and of F
//   MAX_HOLD  maximum consecutive transfers per grant (>= 1)
//
// Ports
//   clk      in   1   single clock, all state updates on the rising edge
//   reset    in   1   synchronous, active-high reset
//   req      in   4   request per requester, bit i = requester i
//   I0..I3   in   N   data from requester 0..3
//   grant    out  4   registered one-hot grant, zero when nobody is granted
//   sel      out  2   mux select, index of the granted requester
//   busy     out  1   high while a grant is held
//   F        out  N   registered mux output
//   valid    out  1   F holds a transfer made in the previous cycle
//------------------------------------------------------------------------------
module rr_mux_arbiter #(
   parameter int N        = 16,
   parameter int MAX_HOLD = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   req,
   input  logic [N-1:0] I0,
   input  logic [N-1:0] I1,
   input  logic [N-1:0] I2,
   input  logic [N-1:0] I3,
   output logic [3:0]   grant,
   output logic [1:0]   sel,
   output logic         busy,
   output logic [N-1:0] F,
   output logic         valid
);

   localparam int CW = $clog2(MAX_HOLD + 1);

   // Last transfer index of a hold window; a transfer at this count ends it.
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   state_t          state_q,    state_d;
   logic [3:0]      grant_q,    grant_d;
   logic [1:0]      sel_q,      sel_d;
   logic [1:0]      ptr_q,      ptr_d;
   logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [N-1:0]    f_q,        f_d;
   logic            valid_q,    valid_d;

   //---------------------------------------------------------------------------
   // Data inputs gathered into an array so the mux is a plain index.
   //---------------------------------------------------------------------------
   logic [N-1:0] din [4];

   always_comb begin
      din[0] = I0;
      din[1] = I1;
      din[2] = I2;
      din[3] = I3;
   end

   //---------------------------------------------------------------------------
   // Round-robin pick: returns {found, index} of the first set request bit
   // scanning start, start+1, ... modulo 4. The loop runs from the far end
   // back to the start so the closest candidate is written last and wins.
   //---------------------------------------------------------------------------
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   //---------------------------------------------------------------------------
   // Arbitration decode
   //---------------------------------------------------------------------------
   logic [2:0] idle_pick;   // winner when starting from IDLE (scan from ptr)
   logic [2:0] rel_pick;    // winner on release (scan from sel+1)
   logic [1:0] sel_next;    // sel + 1, wraps 3 -> 0
   logic       xfer;        // transfer happens this cycle
   logic       release_now; // current grant ends at this edge

   always_comb begin
      sel_next    = sel_q + 2'd1;
      idle_pick   = rr_pick(req, ptr_q);
      rel_pick    = rr_pick(req, sel_next);
      xfer        = (state_q == GRANT) && req[sel_q];
      // A dropped request or an exhausted hold window both end the grant.
      release_now = (state_q == GRANT) &&
                    (!req[sel_q] || (hold_cnt_q == HOLD_LAST));
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      f_d        = f_q;
      valid_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (idle_pick[2]) begin
               state_d    = GRANT;
               grant_d    = 4'b0001 << idle_pick[1:0];
               sel_d      = idle_pick[1:0];
               hold_cnt_d = '0;
            end
         end

         GRANT: begin
            if (xfer) begin
               f_d        = din[sel_q];
               valid_d    = 1'b1;
               hold_cnt_d = hold_cnt_q + CW'(1);
            end

            if (release_now) begin
               ptr_d = sel_next;
               if (rel_pick[2]) begin
                  // Hand over without an idle bubble. If the same requester is
                  // the only one asking, it simply starts a fresh window.
                  grant_d    = 4'b0001 << rel_pick[1:0];
                  sel_d      = rel_pick[1:0];
                  hold_cnt_d = '0;
               end else begin
                  // Nobody left: drop the grant, keep sel as it was.
                  grant_d    = 4'b0000;
                  hold_cnt_d = '0;
                  state_d    = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= 4'b0000;
         sel_q      <= 2'd0;
         ptr_q      <= 2'd0;
         hold_cnt_q <= '0;
         f_q        <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         f_q        <= f_d;
         valid_q    <= valid_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign grant = grant_q;
   assign sel   = sel_q;
   assign busy  = (state_q == GRANT);
   assign F     = f_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
//------------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Directed scenarios followed by a randomized run. A cycle-level model of the
// arbiter (who holds the bus, how many transfers it has made, where the next
// scan starts) predicts grant/sel/busy/F/valid after every clock edge.
//------------------------------------------------------------------------------
module tb_rr_mux_arbiter;

   localparam int N        = 16;
   localparam int MAX_HOLD = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req;
   logic [N-1:0] din_tb [4];
   logic [3:0]   grant;
   logic [1:0]   sel;
   logic         busy;
   logic [N-1:0] F;
   logic         valid;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state
   bit           m_busy;
   int           m_sel;
   int           m_ptr;
   int           m_cnt;
   logic [N-1:0] m_F;
   bit           m_valid;

   rr_mux_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .I0    (din_tb[0]),
      .I1    (din_tb[1]),
      .I2    (din_tb[2]),
      .I3    (din_tb[3]),
      .grant (grant),
      .sel   (sel),
      .busy  (busy),
      .F     (F),
      .valid (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // First requester at or after 'start' (mod 4), or -1 if none.
   function automatic int pick(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int w;
      bit done;
      if (reset) begin
         m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_F = '0; m_valid = 0;
         return;
      end
      if (!m_busy) begin
         m_valid = 0;
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_busy = 1; m_sel = w; m_cnt = 0;
         end
      end else begin
         done = 0;
         if (req[m_sel]) begin
            m_F     = din_tb[m_sel];
            m_valid = 1;
            m_cnt++;
            if (m_cnt == MAX_HOLD) done = 1;
         end else begin
            m_valid = 0;
            done    = 1;
         end
         if (done) begin
            m_ptr = (m_sel + 1) % 4;
            w = pick(req, m_ptr);
            if (w >= 0) begin
               m_sel = w; m_cnt = 0;
            end else begin
               m_busy = 0; m_cnt = 0;
            end
         end
      end
   endtask

   // Drive one cycle of stimulus, clock it, then compare everything.
   // ramp=1 uses Ik = 16'hk000 + cycle, otherwise random data.
   task automatic cycle(input logic rst_v, input logic [3:0] req_v, input bit ramp);
      logic [3:0] exp_grant;
      reset = rst_v;
      req   = req_v;
      for (int k = 0; k < 4; k++) begin
         if (ramp) din_tb[k] = N'(k * 16'h1000 + (cyc & 16'h0fff));
         else      din_tb[k] = N'($urandom);
      end
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      exp_grant = m_busy ? (4'b0001 << m_sel) : 4'b0000;
      check("grant", 32'(grant), 32'(exp_grant));
      check("sel",   32'(sel),   32'(m_sel));
      check("busy",  32'(busy),  32'(m_busy));
      check("valid", 32'(valid), 32'(m_valid));
      check("F",     32'(F),     32'(m_F));
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'h0;
      for (int k = 0; k < 4; k++) din_tb[k] = '0;
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_F = '0; m_valid = 0;

      // 1. Reset held with every request asserted.
      cycle(1'b1, 4'hF, 1'b0);
      cycle(1'b1, 4'hF, 1'b0);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_F",     32'(F),     32'h0);

      // 2. Single requester 0: back-to-back windows of MAX_HOLD transfers.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 4'b0001, 1'b0);
         if (i == 0) check("solo_first_grant", 32'(grant), 32'h1);
      end
      cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0000, 1'b0);

      // 3. Everyone requests: rotation 0,1,2,3,0 with ramp data.
      cycle(1'b1, 4'h0, 1'b1);
      for (int i = 0; i < 22; i++) cycle(1'b0, 4'hF, 1'b1);

      // 4. Requesters 1 and 3; requester 1 drops after two transfers.
      cycle(1'b1, 4'h0, 1'b0);
      cycle(1'b0, 4'b1010, 1'b0);
      cycle(1'b0, 4'b1010, 1'b0);
      cycle(1'b0, 4'b1010, 1'b0);
      cycle(1'b0, 4'b1000, 1'b0);
      check("drop_grant", 32'(grant),     32'h8);
      check("drop_ptr",   32'(dut.ptr_q), 32'd2);
      cycle(1'b0, 4'b1000, 1'b0);
      cycle(1'b0, 4'b0000, 1'b0);
      check("idle_busy", 32'(busy),      32'd0);
      check("idle_ptr",  32'(dut.ptr_q), 32'd0);

      // 5. Reset in the middle of requester 2's window.
      cycle(1'b0, 4'b0100, 1'b0);
      cycle(1'b0, 4'b0100, 1'b0);
      cycle(1'b0, 4'b0100, 1'b0);
      cycle(1'b1, 4'hF, 1'b0);
      check("midrst_valid", 32'(valid), 32'd0);
      cycle(1'b0, 4'hF, 1'b0);
      check("post_rst_grant", 32'(grant), 32'h1);

      // 6. Activity then a quiet period: F must hold its last value.
      cycle(1'b0, 4'hF, 1'b0);
      cycle(1'b0, 4'hF, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, 4'($urandom), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
